memory_stage: RTL

Fourth stage of the 5-stage CPU, directly downstream of the execute stage. Takes the registered ALU result, memory controls and destination from execute. Performs at most one data-memory access per instruction over a req/ack handshake, stalling upstream while it waits. Owns the HI/LO register pair written by multiply/divide completions, and delivers one write-back record per instruction to the wb stage.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/load_align.sv | 26 ++
 rtl/memory_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared size codes, HI/LO register ids, memory FSM states and store helpers
package cpu_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [5:0] REG_HI = 6'd32;
    localparam logic [5:0] REG_LO = 6'd33;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Byte enables for an access of the given size at the given low address bits
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: return 4'b0001 << addr_lo;
            MEM_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            default:  return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane the size can occupy
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEM_BYTE: return {4{data[7:0]}};
            MEM_HALF: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with zero/sign extension
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane and extend it to 32 bits
    always_comb begin
        byte_v = 8'(rdata >> {addr_lo, 3'b000});
        half_v = 16'(rdata >> {addr_lo[1], 4'b0000});
        case (size)
            MEM_BYTE: data = {{24{is_signed & byte_v[7]}}, byte_v};
            MEM_HALF: data = {{16{is_signed & half_v[15]}}, half_v};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - CPU memory stage: data access handshake, HI/LO, write-back record (option: MEM_ALIGN_CHECK_EN)
module memory_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    input  logic        exe_reg_en,
    input  logic        exe_mem_read,
    input  logic        exe_mem_write,
    input  logic [1:0]  exe_mem_size,
    input  logic        exe_is_signed,
    input  logic [5:0]  exe_reg_waddr,
    input  logic [31:0] alu_result_reg,
    input  logic [31:0] exe_store_data,
    input  logic        exe_double_en,
    input  logic [63:0] exe_MD_result,
    output logic        mem_allowin,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_ack,
    output logic        mem_valid,
    output logic        mem_reg_en,
    output logic [5:0]  mem_reg_waddr,
    output logic [31:0] mem_reg_wdata,
    output logic        mem_addr_err,
    output logic [31:0] hi_value,
    output logic [31:0] lo_value
);

    mem_state_e  state_q, state_d;

    logic        is_mem;
    logic        misalign;
    logic        accept;
    logic        go_mem;
    logic        ack_done;
    logic        hilo_ok;

    logic        ld_read;
    logic        ld_reg_en;
    logic [5:0]  ld_waddr;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_addr_lo;
    logic [31:0] load_data;

    logic        md_pend;
    logic [63:0] md_q;

    assign is_mem = exe_mem_read | exe_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = is_mem &&
                      (((exe_mem_size == MEM_HALF) && alu_result_reg[0]) ||
                       (exe_mem_size[1] && (alu_result_reg[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign accept   = (state_q == ST_IDLE) && exe_valid;
    assign go_mem   = accept && is_mem && !misalign;
    assign ack_done = (state_q == ST_WAIT) && data_ack;
    assign hilo_ok  = accept && !misalign;
    assign data_req = (state_q == ST_WAIT);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and stall; ack is only meaningful while a request is outstanding
    always_comb begin
        state_d     = state_q;
        mem_allowin = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_allowin = 1'b1;
                if (go_mem) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch request fields and load controls at accept; they stay stable through WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_wr    <= 1'b0;
            data_be    <= 4'b0000;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            ld_read    <= 1'b0;
            ld_reg_en  <= 1'b0;
            ld_waddr   <= 6'd0;
            ld_size    <= MEM_BYTE;
            ld_signed  <= 1'b0;
            ld_addr_lo <= 2'b00;
        end else if (go_mem) begin
            data_wr    <= exe_mem_write;
            data_be    <= byte_enable(exe_mem_size, alu_result_reg[1:0]);
            data_addr  <= {alu_result_reg[31:2], 2'b00};
            data_wdata <= store_data(exe_mem_size, exe_store_data);
            ld_read    <= exe_mem_read;
            ld_reg_en  <= exe_mem_read & exe_reg_en;
            ld_waddr   <= exe_reg_waddr;
            ld_size    <= exe_mem_size;
            ld_signed  <= exe_is_signed;
            ld_addr_lo <= alu_result_reg[1:0];
        end
    end

    load_align u_load_align (
        .rdata     (data_rdata),
        .addr_lo   (ld_addr_lo),
        .size      (ld_size),
        .is_signed (ld_signed),
        .data      (load_data)
    );

    // Write-back record: one-cycle pulse per completed, faulted or non-memory instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid     <= 1'b0;
            mem_reg_en    <= 1'b0;
            mem_reg_waddr <= 6'd0;
            mem_reg_wdata <= 32'd0;
            mem_addr_err  <= 1'b0;
        end else begin
            mem_valid    <= 1'b0;
            mem_addr_err <= 1'b0;
            if (accept && !go_mem) begin
                mem_valid     <= 1'b1;
                mem_reg_waddr <= exe_reg_waddr;
                if (is_mem) begin
                    mem_reg_en    <= 1'b0;
                    mem_reg_wdata <= 32'd0;
                    mem_addr_err  <= misalign;
                end else begin
                    mem_reg_en    <= exe_reg_en;
                    mem_reg_wdata <= alu_result_reg;
                end
            end else if (ack_done) begin
                mem_valid     <= 1'b1;
                mem_reg_en    <= ld_reg_en;
                mem_reg_waddr <= ld_waddr;
                mem_reg_wdata <= ld_read ? load_data : 32'd0;
            end
        end
    end

    // HI/LO: mult/div result beats a direct write; one arriving mid-WAIT is parked until ack
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_value <= 32'd0;
            lo_value <= 32'd0;
            md_pend  <= 1'b0;
            md_q     <= 64'd0;
        end else if (ack_done && (md_pend || exe_double_en)) begin
            hi_value <= exe_double_en ? exe_MD_result[63:32] : md_q[63:32];
            lo_value <= exe_double_en ? exe_MD_result[31:0]  : md_q[31:0];
            md_pend  <= 1'b0;
        end else if ((state_q == ST_WAIT) && exe_double_en) begin
            md_pend <= 1'b1;
            md_q    <= exe_MD_result;
        end else if (hilo_ok && exe_double_en) begin
            hi_value <= exe_MD_result[63:32];
            lo_value <= exe_MD_result[31:0];
        end else if (hilo_ok && !is_mem && exe_reg_en) begin
            if (exe_reg_waddr == REG_HI) hi_value <= alu_result_reg;
            if (exe_reg_waddr == REG_LO) lo_value <= alu_result_reg;
        end
    end

endmodule
